// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - streaming 3x3 neighbourhood generator with edge replication
//
// Purpose: accepts one 8-bit pixel per cycle in raster order, keeps the two
// previous lines in column-addressed line memories and emits, for every pixel
// position of the frame, the registered 3x3 window centred on it.
// Border positions are filled by edge replication.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready input handshake; a pixel moves when both are high
//   in_pixel          raster-order pixel
//   out_valid         one-cycle pulse per emitted window
//   out_p1..out_p9    window pixels, row-major (p1 top-left, p5 centre)
//   out_first         window centre is (0,0)
//   out_last          window centre is (IMG_HEIGHT-1, IMG_WIDTH-1)

module window_gen_3x3 #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_pixel,
  output logic       out_valid,
  output logic [7:0] out_p1,
  output logic [7:0] out_p2,
  output logic [7:0] out_p3,
  output logic [7:0] out_p4,
  output logic [7:0] out_p5,
  output logic [7:0] out_p6,
  output logic [7:0] out_p7,
  output logic [7:0] out_p8,
  output logic [7:0] out_p9,
  output logic       out_first,
  output logic       out_last
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  // Rows count two past the image: row H is the virtual row replayed during
  // flush, row H+1 column 0 produces the final window.
  localparam int RW = $clog2(IMG_HEIGHT + 2);

  localparam logic [CW-1:0] COL_END  = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_VIRT = RW'(IMG_HEIGHT);
  localparam logic [RW-1:0] ROW_PAST = RW'(IMG_HEIGHT + 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  // Reset: asynchronous assertion, deassertion released through two flops.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;

  // Boundary flags describing the position of the next pixel (or virtual
  // pixel during flush); they drive all replication muxes.
  logic col_zero_q, col_one_q, col_end_q;
  logic row_one_q, row_last_q, row_virt_q, row_past_q;

  logic accept, flush_step, step;
  logic emit, is_first, is_last;

  logic [7:0] line0_mem [IMG_WIDTH];   // previous line
  logic [7:0] line1_mem [IMG_WIDTH];   // line before previous
  logic [7:0] rd0, rd1;

  // Column vectors are {top, mid, bot}; a vector built at column c of input
  // row r covers rows r-2..r and belongs to windows centred on row r-1.
  logic [23:0] vec_in, vec0_q, vec1_q;
  logic [23:0] left_v, centre_v, right_v;
  logic [7:0]  v_top, v_bot;

  logic [7:0] win_q [9];
  logic       out_valid_q, out_first_q, out_last_q;

  assign in_ready   = (state_q != FLUSH);
  assign accept     = in_valid && in_ready;
  assign flush_step = (state_q == FLUSH);
  assign step       = accept || flush_step;

  assign rd0 = line0_mem[col_q];
  assign rd1 = line1_mem[col_q];

  // Top replicated on the first centre row, bottom replicated on the virtual
  // row beyond the image.
  assign v_top  = row_one_q  ? rd0 : rd1;
  assign v_bot  = row_virt_q ? rd0 : in_pixel;
  assign vec_in = {v_top, rd0, v_bot};

  // Column selection: at column 0 the window centre is the last column of the
  // previous centre row (right edge replicated); at column 1 the centre is
  // column 0 (left edge replicated).
  always_comb begin
    left_v   = vec1_q;
    centre_v = vec0_q;
    right_v  = vec_in;
    if (col_zero_q) begin
      right_v = vec0_q;
    end else if (col_one_q) begin
      left_v = vec0_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    emit     = 1'b0;
    is_first = 1'b0;
    is_last  = 1'b0;

    if (step) begin
      if (col_end_q) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    unique case (state_q)
      FILL: begin
        if (accept && row_one_q && col_one_q) begin
          emit     = 1'b1;
          is_first = 1'b1;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (accept) begin
          emit = 1'b1;
          if (row_last_q && col_end_q) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        emit = 1'b1;
        if (row_past_q) begin
          is_last = 1'b1;
          state_d = FILL;
          col_d   = '0;
          row_d   = '0;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= FILL;
      col_q      <= '0;
      row_q      <= '0;
      col_zero_q <= 1'b1;
      col_one_q  <= 1'b0;
      col_end_q  <= 1'b0;
      row_one_q  <= 1'b0;
      row_last_q <= 1'b0;
      row_virt_q <= 1'b0;
      row_past_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      col_zero_q <= (col_d == '0);
      col_one_q  <= (col_d == COL_ONE);
      col_end_q  <= (col_d == COL_END);
      row_one_q  <= (row_d == ROW_ONE);
      row_last_q <= (row_d == ROW_LAST);
      row_virt_q <= (row_d == ROW_VIRT);
      row_past_q <= (row_d == ROW_PAST);
    end
  end

  // Read-before-write: the old previous-line value moves down one line.
  always_ff @(posedge clk) begin
    if (accept) begin
      line1_mem[col_q] <= rd0;
      line0_mem[col_q] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      vec0_q <= '0;
      vec1_q <= '0;
    end else if (step) begin
      vec1_q <= vec0_q;
      vec0_q <= vec_in;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      out_valid_q <= emit;
      if (emit) begin
        out_first_q <= is_first;
        out_last_q  <= is_last;
        win_q[0]    <= left_v[23:16];
        win_q[1]    <= centre_v[23:16];
        win_q[2]    <= right_v[23:16];
        win_q[3]    <= left_v[15:8];
        win_q[4]    <= centre_v[15:8];
        win_q[5]    <= right_v[15:8];
        win_q[6]    <= left_v[7:0];
        win_q[7]    <= centre_v[7:0];
        win_q[8]    <= right_v[7:0];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_first = out_first_q && out_valid_q;
  assign out_last  = out_last_q && out_valid_q;
  assign out_p1    = win_q[0];
  assign out_p2    = win_q[1];
  assign out_p3    = win_q[2];
  assign out_p4    = win_q[3];
  assign out_p5    = win_q[4];
  assign out_p6    = win_q[5];
  assign out_p7    = win_q[6];
  assign out_p8    = win_q[7];
  assign out_p9    = win_q[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb/tb_window_gen_3x3.sv - scoreboard bench for window_gen_3x3 (4x3 directed, 7x5 random)

module tb_window_gen_3x3;

  localparam int AW = 4;
  localparam int AH = 3;
  localparam int BW = 7;
  localparam int BH = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_in_valid = 1'b0, a_in_ready;
  logic [7:0] a_in_pixel = '0;
  logic       a_out_valid, a_first, a_last;
  logic [7:0] a_p1, a_p2, a_p3, a_p4, a_p5, a_p6, a_p7, a_p8, a_p9;

  logic       b_in_valid = 1'b0, b_in_ready;
  logic [7:0] b_in_pixel = '0;
  logic       b_out_valid, b_first, b_last;
  logic [7:0] b_p1, b_p2, b_p3, b_p4, b_p5, b_p6, b_p7, b_p8, b_p9;

  window_gen_3x3 #(.IMG_WIDTH(AW), .IMG_HEIGHT(AH)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pixel(a_in_pixel),
    .out_valid(a_out_valid),
    .out_p1(a_p1), .out_p2(a_p2), .out_p3(a_p3), .out_p4(a_p4), .out_p5(a_p5),
    .out_p6(a_p6), .out_p7(a_p7), .out_p8(a_p8), .out_p9(a_p9),
    .out_first(a_first), .out_last(a_last)
  );

  window_gen_3x3 #(.IMG_WIDTH(BW), .IMG_HEIGHT(BH)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pixel(b_in_pixel),
    .out_valid(b_out_valid),
    .out_p1(b_p1), .out_p2(b_p2), .out_p3(b_p3), .out_p4(b_p4), .out_p5(b_p5),
    .out_p6(b_p6), .out_p7(b_p7), .out_p8(b_p8), .out_p9(b_p9),
    .out_first(b_first), .out_last(b_last)
  );

  typedef struct packed {
    logic [71:0] win;
    logic        first;
    logic        last;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int checks = 0;
  int errors = 0;
  int img[64];

  bit          prev_acc[2];
  bit          prev_fl[2];
  int          run_len[2];
  int          run_val[2];
  int          first_cnt[2];
  int          last_cnt[2];
  int          exp_first[2];
  int          exp_last[2];
  logic [71:0] first_win[2];
  logic [71:0] last_win[2];

  // Reference: window m of a w x h frame, each tap fetched with clamped
  // row/column coordinates.
  task automatic push_model(input int d, input int w, input int h, input int nwin);
    for (int m = 0; m < nwin; m++) begin
      exp_t e;
      int r;
      int c;
      r = m / w;
      c = m % w;
      e.win = '0;
      for (int k = 0; k < 9; k++) begin
        int rr;
        int cc;
        rr = r + k / 3 - 1;
        cc = c + k % 3 - 1;
        if (rr < 0) rr = 0;
        if (rr > h - 1) rr = h - 1;
        if (cc < 0) cc = 0;
        if (cc > w - 1) cc = w - 1;
        e.win[(8 - k) * 8 +: 8] = 8'(img[rr * w + cc]);
      end
      e.first = (m == 0);
      e.last  = (m == w * h - 1);
      if (e.first) exp_first[d]++;
      if (e.last) exp_last[d]++;
      if (d == 0) qa.push_back(e);
      else qb.push_back(e);
    end
  endtask

  task automatic drive(input int d, input int npix, input int mode);
    int idx;
    int guard;
    bit v;
    bit rdy;
    idx = 0;
    guard = 0;
    v = 1'b0;
    while (idx < npix && guard < 8 * npix + 100) begin
      @(posedge clk);
      #1;
      guard++;
      case (mode)
        0:       v = 1'b1;
        1:       v = ~v;
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (d == 0) begin
        a_in_valid = v;
        a_in_pixel = 8'(img[idx]);
        rdy = a_in_ready;
      end else begin
        b_in_valid = v;
        b_in_pixel = 8'(img[idx]);
        rdy = b_in_ready;
      end
      if (v && rdy) idx++;
    end
    if (idx < npix) begin
      errors++;
      $display("FAIL drive_timeout dut%0d: accepted %0d pixels, required %0d", d, idx, npix);
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  // base < 0 selects random pixel values.
  task automatic frame(input int d, input int base, input int mode);
    int w;
    int h;
    w = (d == 0) ? AW : BW;
    h = (d == 0) ? AH : BH;
    for (int i = 0; i < w * h; i++) begin
      img[i] = (base >= 0) ? base + i : int'($urandom_range(0, 255));
    end
    push_model(d, w, h, w * h);
    drive(d, w * h, mode);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((qa.size() != 0 || qb.size() != 0) && g < 500) begin
      @(posedge clk);
      g++;
    end
    repeat (3) @(posedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: windows outstanding a=%0d b=%0d, required 0", qa.size(), qb.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({a_out_valid, a_first, a_last, a_p1, a_p2, a_p3, a_p4, a_p5, a_p6, a_p7, a_p8, a_p9} !== '0
        || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s dut0: valid=%b first=%b last=%b p=%h ready=%b, required all 0 and ready=1",
               tag, a_out_valid, a_first, a_last,
               {a_p1, a_p2, a_p3, a_p4, a_p5, a_p6, a_p7, a_p8, a_p9}, a_in_ready);
    end
    checks++;
    if ({b_out_valid, b_first, b_last, b_p1, b_p2, b_p3, b_p4, b_p5, b_p6, b_p7, b_p8, b_p9} !== '0
        || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s dut1: valid=%b first=%b last=%b p=%h ready=%b, required all 0 and ready=1",
               tag, b_out_valid, b_first, b_last,
               {b_p1, b_p2, b_p3, b_p4, b_p5, b_p6, b_p7, b_p8, b_p9}, b_in_ready);
    end
  endtask

  task automatic check_win(input string tag, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", tag, act, req);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic f, input logic l,
                     input logic [71:0] w, input logic rdy, input logic iv, input int wd);
    exp_t e;
    bit   have;
    if (!rst_n) begin
      prev_acc[d] = 1'b0;
      prev_fl[d]  = 1'b0;
      run_len[d]  = 0;
      run_val[d]  = 0;
      return;
    end
    if (v === 1'b1) begin
      checks++;
      if (!(prev_acc[d] || prev_fl[d])) begin
        errors++;
        $display("FAIL spurious_valid dut%0d: out_valid without acceptance or flush in previous cycle", d);
      end
      have = (d == 0) ? (qa.size() != 0) : (qb.size() != 0);
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL unexpected_window dut%0d: got %h, required no window", d, w);
      end else begin
        e = (d == 0) ? qa.pop_front() : qb.pop_front();
        if (w !== e.win || f !== e.first || l !== e.last) begin
          errors++;
          $display("FAIL window dut%0d: got %h first=%b last=%b, required %h first=%b last=%b",
                   d, w, f, l, e.win, e.first, e.last);
        end
      end
      if (f === 1'b1) begin
        first_cnt[d]++;
        first_win[d] = w;
      end
      if (l === 1'b1) begin
        last_cnt[d]++;
        last_win[d] = w;
      end
    end
    if (rdy === 1'b0) begin
      run_len[d]++;
      if (v === 1'b1) run_val[d]++;
    end else if (run_len[d] > 0) begin
      checks++;
      if (run_len[d] != wd + 1 || run_val[d] != wd + 1) begin
        errors++;
        $display("FAIL flush dut%0d: ready low %0d cycles with %0d valids, required %0d and %0d",
                 d, run_len[d], run_val[d], wd + 1, wd + 1);
      end
      run_len[d] = 0;
      run_val[d] = 0;
    end
    prev_acc[d] = (iv === 1'b1) && (rdy === 1'b1);
    prev_fl[d]  = (rdy === 1'b0);
  endtask

  always @(negedge clk) begin
    mon(0, a_out_valid, a_first, a_last,
        {a_p1, a_p2, a_p3, a_p4, a_p5, a_p6, a_p7, a_p8, a_p9}, a_in_ready, a_in_valid, AW);
    mon(1, b_out_valid, b_first, b_last,
        {b_p1, b_p2, b_p3, b_p4, b_p5, b_p6, b_p7, b_p8, b_p9}, b_in_ready, b_in_valid, BW);
  end

  localparam logic [71:0] A_FIRST  = 72'h00_00_01_00_00_01_04_04_05;
  localparam logic [71:0] A_LAST   = 72'h06_07_07_0A_0B_0B_0A_0B_0B;
  localparam logic [71:0] A2_FIRST = 72'h64_64_65_64_64_65_68_68_69;

  initial begin
    for (int d = 0; d < 2; d++) begin
      first_cnt[d] = 0;
      last_cnt[d]  = 0;
      exp_first[d] = 0;
      exp_last[d]  = 0;
      first_win[d] = '0;
      last_win[d]  = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Linear-index frame, continuous valid.
    frame(0, 0, 0);
    drain();
    check_win("first_window", first_win[0], A_FIRST);
    check_win("last_window", last_win[0], A_LAST);

    // Same frame with in_valid toggling.
    first_win[0] = '0;
    last_win[0]  = '0;
    frame(0, 0, 1);
    drain();
    check_win("toggle_first_window", first_win[0], A_FIRST);
    check_win("toggle_last_window", last_win[0], A_LAST);

    // Back-to-back frames.
    frame(0, 0, 0);
    frame(0, 100, 0);
    drain();
    check_win("frame2_first_window", first_win[0], A2_FIRST);

    // Reset after 7 pixels, then a full frame.
    for (int i = 0; i < AW * AH; i++) img[i] = i;
    push_model(0, AW, AH, 7 - AW - 1);
    drive(0, 7, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    check_reset_outputs("midframe_reset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_hold");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    first_win[0] = '0;
    last_win[0]  = '0;
    frame(0, 0, 0);
    drain();
    check_win("post_reset_first_window", first_win[0], A_FIRST);
    check_win("post_reset_last_window", last_win[0], A_LAST);

    // Random images, random valid gaps.
    for (int n = 0; n < 4; n++) frame(0, -1, 2);
    for (int n = 0; n < 8; n++) frame(1, -1, 2 - (n % 3 == 0 ? 2 : 0));
    drain();

    for (int d = 0; d < 2; d++) begin
      checks++;
      if (first_cnt[d] != exp_first[d] || last_cnt[d] != exp_last[d]) begin
        errors++;
        $display("FAIL frame_markers dut%0d: first=%0d last=%0d, required first=%0d last=%0d",
                 d, first_cnt[d], last_cnt[d], exp_first[d], exp_last[d]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
